// File: rtl/writer_type_2_pkg.sv
// Shared type-2 code definitions: opcode, field positions, FSM encoding, address width.
package type2_code_pkg;
  localparam logic [1:0] TYPE2_OP = 2'b10;

  // Field positions counted down from the code MSB; address sits at bit 0.
  localparam int OP_W         = 2;
  localparam int SEL_FROM_TOP = 3;
  localparam int ADDR_LSB     = 0;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  localparam logic [1:0] ST_IDLE  = S_IDLE;
  localparam logic [1:0] ST_WRITE = S_WRITE;
  localparam logic [1:0] ST_WAIT  = S_WAIT;
  localparam logic [1:0] ST_DONE  = S_DONE;

  function automatic int addr_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/writer_type_2_if.sv
// Request / memory-write bundle between a producer (master) and writer_type_2 (slave).
interface writer_type_2_if #(
  parameter int DATA_WIDTH  = 32,
  parameter int CODE_WIDTH  = 8,
  parameter int NUM_KEY_VAL = 12,
  parameter int ADDR_W      = type2_code_pkg::addr_w(NUM_KEY_VAL)
);
  logic                  write_start;
  logic                  write_ready;
  logic [CODE_WIDTH-1:0] inp_code;
  logic [DATA_WIDTH-1:0] in_value;
  logic [ADDR_W-1:0]     mem_key_val_addr;
  logic [DATA_WIDTH-1:0] mem_key_val_data_in;
  logic                  mem_key_val_wr_en;
  logic [ADDR_W-1:0]     mem_state_var_addr;
  logic [DATA_WIDTH-1:0] mem_state_var_data_in;
  logic                  mem_state_var_wr_en;
  logic                  write_done;
  logic                  write_error;

  modport master (
    output write_start, inp_code, in_value,
    input  write_ready, mem_key_val_addr, mem_key_val_data_in, mem_key_val_wr_en,
           mem_state_var_addr, mem_state_var_data_in, mem_state_var_wr_en,
           write_done, write_error
  );

  modport slave (
    input  write_start, inp_code, in_value,
    output write_ready, mem_key_val_addr, mem_key_val_data_in, mem_key_val_wr_en,
           mem_state_var_addr, mem_state_var_data_in, mem_state_var_wr_en,
           write_done, write_error
  );
endinterface

// File: rtl/writer_type_2_fifo.sv
// Request queue: first-word-fall-through FIFO, head readable while not empty.
module sync_fifo import type2_code_pkg::*; #(
  parameter int WIDTH = 40,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_do_push;
  logic             w_do_pop;

  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  always_ff @(posedge clock) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Extra pointer bit distinguishes full from empty when the indices coincide.
  assign o_data  = r_mem[r_rd_ptr[AW-1:0]];
  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
endmodule

// File: rtl/writer_type_2.sv
// Type-2 write engine: queues (code, value) requests, decodes them and drives the
// key-value / state-variable memory write ports, one request per MEM_DELAY+2 cycles.
module writer_type_2 import type2_code_pkg::*; #(
  parameter int DATA_WIDTH  = 32,
  parameter int CODE_WIDTH  = 8,
  parameter int NUM_KEY_VAL = 12,
  parameter int MEM_DELAY   = 2,
  parameter int FIFO_DEPTH  = 4
) (
  input logic             clock,
  input logic             reset,
  writer_type_2_if.slave  bus
);
  localparam int ADDR_W  = addr_w(NUM_KEY_VAL);
  localparam int ENTRY_W = DATA_WIDTH + CODE_WIDTH;
  localparam int CNT_W   = (MEM_DELAY > 1) ? $clog2(MEM_DELAY) : 1;
  localparam logic [ADDR_W:0] ADDR_LIMIT = (ADDR_W+1)'(NUM_KEY_VAL);

  logic [1:0]            r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_err;
  logic [ADDR_W-1:0]     r_key_addr;
  logic [DATA_WIDTH-1:0] r_key_data;
  logic                  r_key_wr_en;
  logic [ADDR_W-1:0]     r_sv_addr;
  logic [DATA_WIDTH-1:0] r_sv_data;
  logic                  r_sv_wr_en;
  logic                  r_done;
  logic                  r_error;

  logic                  w_push;
  logic                  w_pop;
  logic                  w_full;
  logic                  w_empty;
  logic [ENTRY_W-1:0]    w_head;
  logic [CODE_WIDTH-1:0] w_code;
  logic [DATA_WIDTH-1:0] w_value;
  logic [OP_W-1:0]       w_op;
  logic                  w_sel;
  logic [ADDR_W-1:0]     w_addr;
  logic                  w_err;
  logic                  w_unused;

  assign w_push = bus.write_start && !w_full;
  assign w_pop  = !w_empty && ((r_state == ST_IDLE) || (r_state == ST_DONE));

  sync_fifo #(.WIDTH(ENTRY_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .i_push  (w_push),
    .i_data  ({bus.in_value, bus.inp_code}),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign w_code   = w_head[CODE_WIDTH-1:0];
  assign w_value  = w_head[ENTRY_W-1:CODE_WIDTH];
  assign w_op     = w_code[CODE_WIDTH-1 -: OP_W];
  assign w_sel    = w_code[CODE_WIDTH-SEL_FROM_TOP];
  assign w_addr   = w_code[ADDR_LSB +: ADDR_W];
  assign w_err    = (w_op != TYPE2_OP) || ({1'b0, w_addr} >= ADDR_LIMIT);
  assign w_unused = ^w_code;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_err       <= 1'b0;
      r_key_addr  <= '0;
      r_key_data  <= '0;
      r_key_wr_en <= 1'b0;
      r_sv_addr   <= '0;
      r_sv_data   <= '0;
      r_sv_wr_en  <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      r_key_wr_en <= 1'b0;
      r_sv_wr_en  <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (w_pop) begin
            r_err   <= w_err;
            r_state <= ST_WRITE;
            // Rejected requests leave both memory ports untouched.
            if (!w_err) begin
              if (w_sel) begin
                r_sv_addr  <= w_addr;
                r_sv_data  <= w_value;
                r_sv_wr_en <= 1'b1;
              end else begin
                r_key_addr  <= w_addr;
                r_key_data  <= w_value;
                r_key_wr_en <= 1'b1;
              end
            end
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_WRITE: begin
          r_cnt   <= CNT_W'(MEM_DELAY - 1);
          r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (r_cnt == '0) begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
            r_error <= r_err;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.write_ready           = !w_full;
  assign bus.mem_key_val_addr      = r_key_addr;
  assign bus.mem_key_val_data_in   = r_key_data;
  assign bus.mem_key_val_wr_en     = r_key_wr_en;
  assign bus.mem_state_var_addr    = r_sv_addr;
  assign bus.mem_state_var_data_in = r_sv_data;
  assign bus.mem_state_var_wr_en   = r_sv_wr_en;
  assign bus.write_done            = r_done;
  assign bus.write_error           = r_error;
endmodule

// File: tb/tb_writer_type_2.sv
// Directed bench for writer_type_2: cycle-exact latency, decode, errors, queueing, reset.
module tb_writer_type_2;
  import type2_code_pkg::*;

  localparam int DW  = 32;
  localparam int CW  = 8;
  localparam int NKV = 12;
  localparam int MD  = 2;
  localparam int FD  = 4;
  localparam int AW  = addr_w(NKV);

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  writer_type_2_if #(.DATA_WIDTH(DW), .CODE_WIDTH(CW), .NUM_KEY_VAL(NKV)) bus ();

  writer_type_2 #(
    .DATA_WIDTH(DW), .CODE_WIDTH(CW), .NUM_KEY_VAL(NKV), .MEM_DELAY(MD), .FIFO_DEPTH(FD)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int n_pass   = 0;
  int n_checks = 0;
  int n_fail   = 0;

  // Passive log of every write strobe and done pulse, in the order they occur.
  int          cyc = 0;
  int          n_wr = 0;
  int          n_done = 0;
  logic        log_sel  [64];
  logic [AW-1:0] log_addr [64];
  logic [DW-1:0] log_data [64];
  int          done_cyc [64];
  logic        done_err [64];

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (bus.mem_key_val_wr_en && n_wr < 64) begin
      log_sel[n_wr] = 1'b0; log_addr[n_wr] = bus.mem_key_val_addr;
      log_data[n_wr] = bus.mem_key_val_data_in; n_wr++;
    end
    if (bus.mem_state_var_wr_en && n_wr < 64) begin
      log_sel[n_wr] = 1'b1; log_addr[n_wr] = bus.mem_state_var_addr;
      log_data[n_wr] = bus.mem_state_var_data_in; n_wr++;
    end
    if (bus.write_done && n_done < 64) begin
      done_cyc[n_done] = cyc; done_err[n_done] = bus.write_error; n_done++;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock); #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Presents one request for a single cycle while the queue has room.
  task automatic accept(input logic [CW-1:0] c, input logic [DW-1:0] v);
    bus.write_start = 1'b1; bus.inp_code = c; bus.in_value = v;
    step();
    bus.write_start = 1'b0;
  endtask

  // Holds a request until write_ready, then lets the next edge take it.
  task automatic push(input logic [CW-1:0] c, input logic [DW-1:0] v);
    int k;
    bus.write_start = 1'b1; bus.inp_code = c; bus.in_value = v;
    k = 0;
    while (!bus.write_ready && k < 50) begin step(); k++; end
    check("push_ready", bus.write_ready, 1'b1);
    step();
    bus.write_start = 1'b0;
  endtask

  logic [CW-1:0] t4_code [6] = '{8'h90, 8'hA1, 8'h8B, 8'hAA, 8'h84, 8'hA7};
  logic          t4_sel  [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
  logic [AW-1:0] t4_addr [6] = '{4'd0, 4'd1, 4'd11, 4'd10, 4'd4, 4'd7};

  int base_wr;
  int base_done;

  initial begin
    reset = 1'b1; bus.write_start = 1'b0; bus.inp_code = '0; bus.in_value = '0;
    steps(2);
    check("rst_key_wr_en", bus.mem_key_val_wr_en, 1'b0);
    check("rst_done", bus.write_done, 1'b0);
    check("rst_key_addr", bus.mem_key_val_addr, 4'd0);
    check("rst_sv_data", bus.mem_state_var_data_in, 32'd0);
    reset = 1'b0;
    check("rst_ready_after_release", bus.write_ready, 1'b1);
    step();

    // Test 1: key-value write, cycle-exact latency
    accept(8'h83, 32'hDEADBEEF);                        // now T+1
    check("t1_wr_en_T1", bus.mem_key_val_wr_en, 1'b0);
    step();                                              // T+2
    check("t1_key_wr_en_T2", bus.mem_key_val_wr_en, 1'b1);
    check("t1_sv_wr_en_T2", bus.mem_state_var_wr_en, 1'b0);
    check("t1_key_addr", bus.mem_key_val_addr, 4'd3);
    check("t1_key_data", bus.mem_key_val_data_in, 32'hDEADBEEF);
    step();                                              // T+3
    check("t1_wr_en_drop_T3", bus.mem_key_val_wr_en, 1'b0);
    check("t1_addr_held_T3", bus.mem_key_val_addr, 4'd3);
    step();                                              // T+4
    check("t1_done_early_T4", bus.write_done, 1'b0);
    step();                                              // T+5
    check("t1_done_T5", bus.write_done, 1'b1);
    check("t1_error_T5", bus.write_error, 1'b0);
    step();
    check("t1_done_pulse_end", bus.write_done, 1'b0);

    // Test 2: state-variable write, key-value port untouched
    accept(8'hA5, 32'h1234);
    step();
    check("t2_sv_wr_en", bus.mem_state_var_wr_en, 1'b1);
    check("t2_key_wr_en", bus.mem_key_val_wr_en, 1'b0);
    check("t2_sv_addr", bus.mem_state_var_addr, 4'd5);
    check("t2_sv_data", bus.mem_state_var_data_in, 32'h1234);
    check("t2_key_addr_hold", bus.mem_key_val_addr, 4'd3);
    check("t2_key_data_hold", bus.mem_key_val_data_in, 32'hDEADBEEF);
    steps(3);
    check("t2_done", bus.write_done, 1'b1);
    check("t2_error", bus.write_error, 1'b0);
    step();

    // Test 3: out-of-range address and wrong opcode
    base_wr = n_wr;
    accept(8'h8C, 32'h77);
    step();
    check("t3a_key_wr_en", bus.mem_key_val_wr_en, 1'b0);
    check("t3a_sv_wr_en", bus.mem_state_var_wr_en, 1'b0);
    steps(3);
    check("t3a_done", bus.write_done, 1'b1);
    check("t3a_error", bus.write_error, 1'b1);
    step();
    accept(8'h43, 32'h88);
    steps(4);
    check("t3b_done", bus.write_done, 1'b1);
    check("t3b_error", bus.write_error, 1'b1);
    check("t3_no_writes", n_wr - base_wr, 0);
    check("t3_key_addr_hold", bus.mem_key_val_addr, 4'd3);
    check("t3_sv_addr_hold", bus.mem_state_var_addr, 4'd5);
    step();

    // Test 4 + 6: five back-to-back pushes fill the queue, sixth held until ready
    base_wr = n_wr; base_done = n_done;
    for (int i = 0; i < 5; i++) push(t4_code[i], 32'h100 + i);
    check("t4_ready_low_full", bus.write_ready, 1'b0);
    bus.write_start = 1'b1; bus.inp_code = t4_code[5]; bus.in_value = 32'h105;
    step();
    check("t6_ready_rises", bus.write_ready, 1'b1);
    step();
    bus.write_start = 1'b0;
    for (int k = 0; k < 200 && n_done < base_done + 6; k++) step();
    steps(10);
    check("t4_write_count", n_wr - base_wr, 6);
    check("t4_done_count", n_done - base_done, 6);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("t4_sel_%0d", i), log_sel[base_wr+i], t4_sel[i]);
      check($sformatf("t4_addr_%0d", i), log_addr[base_wr+i], t4_addr[i]);
      check($sformatf("t4_data_%0d", i), log_data[base_wr+i], 32'h100 + i);
      check($sformatf("t4_err_%0d", i), done_err[base_done+i], 1'b0);
    end
    for (int i = 0; i < 5; i++)
      check($sformatf("t4_done_spacing_%0d", i),
            done_cyc[base_done+i+1] - done_cyc[base_done+i], MD + 2);

    // Test 5: reset during WAIT loses the request
    accept(8'h83, 32'h55);
    steps(2);                                            // T+3, WAIT
    reset = 1'b1;
    #1;
    check("t5_wr_en_in_reset", bus.mem_key_val_wr_en, 1'b0);
    check("t5_done_in_reset", bus.write_done, 1'b0);
    check("t5_addr_in_reset", bus.mem_key_val_addr, 4'd0);
    step();
    reset = 1'b0;
    base_wr = n_wr; base_done = n_done;
    check("t5_ready_after_release", bus.write_ready, 1'b1);
    steps(8);
    check("t5_no_done", n_done - base_done, 0);
    check("t5_no_write", n_wr - base_wr, 0);
    accept(8'h83, 32'hDEADBEEF);
    step();
    check("t5_retry_wr_en", bus.mem_key_val_wr_en, 1'b1);
    check("t5_retry_addr", bus.mem_key_val_addr, 4'd3);
    check("t5_retry_data", bus.mem_key_val_data_in, 32'hDEADBEEF);
    steps(3);
    check("t5_retry_done", bus.write_done, 1'b1);
    check("t5_retry_error", bus.write_error, 1'b0);
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
